// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
//   Receive side of the 5-state sequence generator. Watches the 3-bit state
//   code the generator emits and recovers the input bit 'a' that selected each
//   branch. Every step is checked against the legal transition graph:
//     0->3 (-), 3->5 (a=1), 3->2 (a=0), 2->4 (-), 4->3 (a=1), 4->0 (a=0), 5->2 (-)
//   Codes 1, 6 and 7 are invalid, and a repeated code is an illegal step.
//   The block locks after LOCK_N consecutive legal steps. While locked it
//   flags (and counts) violations, and it resynchronises on its own.
//
// Parameters
//   LOCK_N     consecutive legal transitions needed to enter LOCK (1..7)
//   CNT_W      width of the saturating error counter
//
// Ports
//   clk        clock, rising edge
//   res        asynchronous reset, active-low
//   s_in       state code from the generator
//   s_vld      s_in carries a new symbol this cycle; state holds when low
//   err_clr    synchronous clear of err_cnt (wins over an increment)
//   a_out      recovered bit, meaningful while a_vld=1, holds otherwise
//   a_vld      one-cycle pulse: a_out holds a newly decoded bit
//   err        one-cycle pulse: illegal symbol/transition seen while locked
//   locked     1 while the FSM is in LOCK
//   err_cnt    saturating count of err pulses
//   fsm_state  current FSM state (debug): 0=HUNT, 1=CHECK, 2=LOCK
//
// Handshake: a symbol is consumed on every rising edge where s_vld=1; there
// is no backpressure. All responses are registered and appear the cycle
// after the sampling edge.
// -----------------------------------------------------------------------------
module seq_decoder #(
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [2:0]       s_in,
  input  logic             s_vld,
  input  logic             err_clr,
  output logic             a_out,
  output logic             a_vld,
  output logic             err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       fsm_state
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_LOCK  = 2'd2;

  localparam logic [2:0]       LOCK_N3 = 3'(LOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       fsm, fsm_n;
  logic [2:0]       prev, prev_n;
  logic [2:0]       cnt, cnt_n;
  logic [2:0]       cnt_inc;
  logic             a_out_n, a_vld_n, err_n;
  logic [CNT_W-1:0] err_cnt_n;

  // Step classification of (prev -> s_in).
  logic code_ok;      // s_in is one of the five legal codes
  logic step_ok;      // prev -> s_in is an edge of the graph
  logic step_bit_en;  // that edge is a branch and carries a bit
  logic step_bit;     // the bit carried by a branching edge

  always_comb begin
    code_ok = (s_in == 3'd0) || (s_in == 3'd2) || (s_in == 3'd3) ||
              (s_in == 3'd4) || (s_in == 3'd5);
  end

  always_comb begin
    step_ok     = 1'b0;
    step_bit_en = 1'b0;
    step_bit    = 1'b0;
    case ({prev, s_in})
      6'o03: step_ok = 1'b1;
      6'o35: begin step_ok = 1'b1; step_bit_en = 1'b1; step_bit = 1'b1; end
      6'o32: begin step_ok = 1'b1; step_bit_en = 1'b1; step_bit = 1'b0; end
      6'o24: step_ok = 1'b1;
      6'o43: begin step_ok = 1'b1; step_bit_en = 1'b1; step_bit = 1'b1; end
      6'o40: begin step_ok = 1'b1; step_bit_en = 1'b1; step_bit = 1'b0; end
      6'o52: step_ok = 1'b1;
      default: step_ok = 1'b0;
    endcase
  end

  assign cnt_inc = cnt + 3'd1;

  always_comb begin
    fsm_n   = fsm;
    prev_n  = prev;
    cnt_n   = cnt;
    a_out_n = a_out;
    a_vld_n = 1'b0;
    err_n   = 1'b0;
    if (s_vld) begin
      case (fsm)
        S_HUNT: begin
          if (code_ok) begin
            prev_n = s_in;
            cnt_n  = 3'd0;
            fsm_n  = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!code_ok) begin
            fsm_n = S_HUNT;
          end else if (step_ok) begin
            prev_n = s_in;
            cnt_n  = cnt_inc;
            // The locking step itself never emits a bit.
            if (cnt_inc == LOCK_N3) fsm_n = S_LOCK;
          end else begin
            prev_n = s_in;
            cnt_n  = 3'd0;
          end
        end
        S_LOCK: begin
          if (!code_ok) begin
            err_n = 1'b1;
            fsm_n = S_HUNT;
          end else if (step_ok) begin
            prev_n = s_in;
            if (step_bit_en) begin
              a_vld_n = 1'b1;
              a_out_n = step_bit;
            end
          end else begin
            // Illegal step to a valid code: restart the lock count from it.
            err_n  = 1'b1;
            prev_n = s_in;
            cnt_n  = 3'd0;
            fsm_n  = S_CHECK;
          end
        end
        default: fsm_n = S_HUNT;
      endcase
    end
  end

  always_comb begin
    err_cnt_n = err_cnt;
    if (err_clr) begin
      err_cnt_n = '0;
    end else if (err_n && (err_cnt != CNT_MAX)) begin
      err_cnt_n = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fsm     <= S_HUNT;
      prev    <= 3'd0;
      cnt     <= 3'd0;
      a_out   <= 1'b0;
      a_vld   <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      fsm     <= fsm_n;
      prev    <= prev_n;
      cnt     <= cnt_n;
      a_out   <= a_out_n;
      a_vld   <= a_vld_n;
      err     <= err_n;
      err_cnt <= err_cnt_n;
    end
  end

  assign locked    = (fsm == S_LOCK);
  assign fsm_state = fsm;

endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
//   Three decoders share one stimulus stream:
//     u0: LOCK_N=2, CNT_W=8   u1: LOCK_N=2, CNT_W=2   u2: LOCK_N=1, CNT_W=8
//   A reference model built on the transition-graph edge list tracks each
//   instance and every output is compared one time unit after each edge.
// -----------------------------------------------------------------------------
module tb_seq_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res;
  logic [2:0] s_in;
  logic       s_vld;
  logic       err_clr;

  logic       a_out_w[3];
  logic       a_vld_w[3];
  logic       err_w[3];
  logic       locked_w[3];
  logic [1:0] st_w[3];
  logic [7:0] ec0, ec2;
  logic [1:0] ec1;
  logic [7:0] obs_cnt[3];

  assign obs_cnt[0] = ec0;
  assign obs_cnt[1] = {6'd0, ec1};
  assign obs_cnt[2] = ec2;

  seq_decoder #(.LOCK_N(2), .CNT_W(8)) u0 (
    .clk(clk), .res(res), .s_in(s_in), .s_vld(s_vld), .err_clr(err_clr),
    .a_out(a_out_w[0]), .a_vld(a_vld_w[0]), .err(err_w[0]), .locked(locked_w[0]),
    .err_cnt(ec0), .fsm_state(st_w[0]));

  seq_decoder #(.LOCK_N(2), .CNT_W(2)) u1 (
    .clk(clk), .res(res), .s_in(s_in), .s_vld(s_vld), .err_clr(err_clr),
    .a_out(a_out_w[1]), .a_vld(a_vld_w[1]), .err(err_w[1]), .locked(locked_w[1]),
    .err_cnt(ec1), .fsm_state(st_w[1]));

  seq_decoder #(.LOCK_N(1), .CNT_W(8)) u2 (
    .clk(clk), .res(res), .s_in(s_in), .s_vld(s_vld), .err_clr(err_clr),
    .a_out(a_out_w[2]), .a_vld(a_vld_w[2]), .err(err_w[2]), .locked(locked_w[2]),
    .err_cnt(ec2), .fsm_state(st_w[2]));

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0] s;
    logic       v;
    logic       c;
  } stim_t;

  function automatic stim_t mk(input int s, input bit v, input bit c);
    stim_t t;
    t.s = 3'(s);
    t.v = v;
    t.c = c;
    return t;
  endfunction

  // ---------------- reference model ----------------
  // Transition graph as an edge list; bit -1 means the edge carries no bit.
  int e_from[7] = '{0, 3, 3, 2, 4, 4, 5};
  int e_to[7]   = '{3, 5, 2, 4, 3, 0, 2};
  int e_bit[7]  = '{-1, 1, 0, -1, 1, 0, -1};

  int lk[3]   = '{2, 2, 1};
  int cmax[3] = '{255, 3, 255};

  // mode: 0 hunting, 1 checking, 2 locked
  int   m_mode[3];
  int   m_prev[3];
  int   m_run[3];
  int   m_ecnt[3];
  logic m_aout[3];
  logic m_avld[3];
  logic m_err[3];

  // -2: not an edge, -1: edge without bit, 0/1: bit carried
  function automatic int edge_bit(input int from, input int to);
    for (int i = 0; i < 7; i++)
      if (e_from[i] == from && e_to[i] == to) return e_bit[i];
    return -2;
  endfunction

  function automatic bit code_valid(input int s);
    return (s == 0) || (s == 2) || (s == 3) || (s == 4) || (s == 5);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_ecnt[k] = 0;
      m_aout[k] = 1'b0; m_avld[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int s, input bit v, input bit c);
    int b;
    for (int k = 0; k < 3; k++) begin
      m_avld[k] = 1'b0;
      m_err[k]  = 1'b0;
      if (v) begin
        b = edge_bit(m_prev[k], s);
        if (!code_valid(s)) begin
          if (m_mode[k] == 2) m_err[k] = 1'b1;
          m_mode[k] = 0;
        end else if (m_mode[k] == 0) begin
          m_prev[k] = s; m_run[k] = 0; m_mode[k] = 1;
        end else if (b == -2) begin
          if (m_mode[k] == 2) m_err[k] = 1'b1;
          m_prev[k] = s; m_run[k] = 0; m_mode[k] = 1;
        end else begin
          m_prev[k] = s;
          if (m_mode[k] == 2) begin
            if (b >= 0) begin m_avld[k] = 1'b1; m_aout[k] = b[0]; end
          end else begin
            m_run[k]++;
            if (m_run[k] == lk[k]) m_mode[k] = 2;
          end
        end
      end
      if (c) m_ecnt[k] = 0;
      else if (m_err[k] && m_ecnt[k] < cmax[k]) m_ecnt[k]++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    res = 1'b0; s_vld = 1'b0; err_clr = 1'b0; s_in = 3'd0;
    #1;
    model_reset();
    @(negedge clk);
    res = 1'b1;
  endtask

  // Drive one symbol on the falling edge, advance the model at the rising
  // edge, and return 1 time unit later so outputs can be sampled.
  task automatic run_step(input stim_t t);
    @(negedge clk);
    s_in = t.s; s_vld = t.v; err_clr = t.c;
    @(posedge clk);
    model_step(int'(t.s), t.v, t.c);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    res = 1'b0; s_in = 3'd0; s_vld = 1'b0; err_clr = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      n_run++;
      if ({a_out_w[k], a_vld_w[k], err_w[k], locked_w[k]} !== 4'b0 ||
          obs_cnt[k] !== 8'd0 || st_w[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset u%0d: out/vld/err/lock %b%b%b%b cnt %0d state %0d, expected all 0",
                 k, a_out_w[k], a_vld_w[k], err_w[k], locked_w[k], obs_cnt[k], st_w[k]);
      end
    end
    @(negedge clk);
    res = 1'b1;
  endtask

  task automatic test_basic();
    stim_t q[$];
    logic bits[$];
    int seq[9] = '{0, 3, 5, 2, 4, 3, 2, 4, 0};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL basic u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (a_vld_w[0] === 1'b1) bits.push_back(a_out_w[0]);
      if (i == 1 || i == 2) begin
        n_run++;
        if (locked_w[0] !== (i == 2)) begin
          n_fail++;
          $display("FAIL basic_lock_edge step %0d: locked %b, expected %b", i, locked_w[0], i == 2);
        end
      end
    end
    n_run++;
    if (bits.size() != 3 || {bits[0], bits[1], bits[2]} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_bits: %0d bits decoded, expected 3 bits 1,0,0", bits.size());
    end
  endtask

  task automatic test_repeat();
    stim_t q[$];
    int seq[9] = '{0, 3, 5, 2, 4, 3, 3, 5, 2};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL repeat u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (i == 6) begin
        n_run++;
        if ({err_w[0], locked_w[0]} !== 2'b10 || ec0 !== 8'd1) begin
          n_fail++;
          $display("FAIL repeat_err: err/lock %b%b cnt %0d, expected 10 cnt 1", err_w[0], locked_w[0], ec0);
        end
      end
      if (i == 8) begin
        n_run++;
        if (locked_w[0] !== 1'b1) begin
          n_fail++;
          $display("FAIL repeat_relock: locked %b, expected 1", locked_w[0]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    stim_t q[$];
    int seq[6] = '{0, 3, 5, 6, 0, 3};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL invalid u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (i == 3 || i == 4) begin
        n_run++;
        if ({err_w[0], locked_w[0]} !== {i == 3, 1'b0}) begin
          n_fail++;
          $display("FAIL invalid_hunt step %0d: err/lock %b%b, expected %b0", i, err_w[0], locked_w[0], i == 3);
        end
      end
    end
  endtask

  task automatic test_saturate();
    stim_t q[$];
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      q.push_back(mk(0, 1, 0)); q.push_back(mk(3, 1, 0));
      q.push_back(mk(5, 1, 0)); q.push_back(mk(6, 1, 0));
    end
    q.push_back(mk(0, 1, 0)); q.push_back(mk(3, 1, 0));
    q.push_back(mk(5, 1, 0)); q.push_back(mk(6, 1, 1));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL saturate u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (i == 19) begin
        n_run++;
        if (ec1 !== 2'd3 || ec0 !== 8'd5) begin
          n_fail++;
          $display("FAIL saturate_hold: narrow cnt %0d wide cnt %0d, expected 3 and 5", ec1, ec0);
        end
      end
      if (i == 23) begin
        n_run++;
        if (err_w[1] !== 1'b1 || ec1 !== 2'd0 || ec0 !== 8'd0) begin
          n_fail++;
          $display("FAIL saturate_clr: err %b narrow cnt %0d wide cnt %0d, expected err 1 cnt 0/0",
                   err_w[1], ec1, ec0);
        end
      end
    end
  endtask

  task automatic test_svld();
    stim_t q[$];
    int seq[5] = '{0, 3, 5, 2, 4};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    q.push_back(mk(0, 1, 0)); q.push_back(mk($urandom_range(0, 7), 0, 0));
    q.push_back(mk(3, 1, 0)); q.push_back(mk($urandom_range(0, 7), 0, 0));
    q.push_back(mk(5, 1, 0)); q.push_back(mk($urandom_range(0, 7), 0, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL svld u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (i >= 5) begin
        n_run++;
        if ({a_vld_w[0], locked_w[0]} !== {i == 5 || i == 9, 1'b1} || (i == 9 && a_out_w[0] !== 1'b1)) begin
          n_fail++;
          $display("FAIL svld_gap step %0d: vld/lock/out %b%b%b", i, a_vld_w[0], locked_w[0], a_out_w[0]);
        end
      end
    end
  endtask

  task automatic test_lock1();
    stim_t q[$];
    int seq[3] = '{0, 3, 2};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL lock1 u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
      if (i == 1) begin
        n_run++;
        if ({locked_w[2], a_vld_w[2]} !== 2'b10) begin
          n_fail++;
          $display("FAIL lock1_enter: lock/vld %b%b, expected 10", locked_w[2], a_vld_w[2]);
        end
      end
      if (i == 2) begin
        n_run++;
        if ({a_vld_w[2], a_out_w[2]} !== 2'b10) begin
          n_fail++;
          $display("FAIL lock1_bit: vld/out %b%b, expected 10", a_vld_w[2], a_out_w[2]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t q[$];
    int seq[6] = '{0, 3, 5, 2, 4, 3};
    apply_reset();
    foreach (seq[i]) q.push_back(mk(seq[i], 1, 0));
    foreach (q[i]) run_step(q[i]);
    // Mid-cycle, between edges: outputs must clear without a clock edge.
    #2;
    res = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_run++;
      if ({a_out_w[k], a_vld_w[k], err_w[k], locked_w[k]} !== 4'b0 ||
          obs_cnt[k] !== 8'd0 || st_w[k] !== 2'd0) begin
        n_fail++;
        $display("FAIL async_reset u%0d: out/vld/err/lock %b%b%b%b cnt %0d state %0d, expected all 0",
                 k, a_out_w[k], a_vld_w[k], err_w[k], locked_w[k], obs_cnt[k], st_w[k]);
      end
    end
    model_reset();
    @(negedge clk);
    res = 1'b1;
    q.delete();
    q.push_back(mk(3, 1, 0)); q.push_back(mk(5, 1, 0)); q.push_back(mk(2, 1, 0));
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL async_after u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    stim_t q[$];
    int walk = 0;
    int succ[$];
    int s;
    bit v;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) begin
        succ.delete();
        for (int e = 0; e < 7; e++) if (e_from[e] == walk) succ.push_back(e_to[e]);
        s = succ[$urandom_range(0, succ.size() - 1)];
      end else begin
        s = $urandom_range(0, 7);
      end
      if (v && code_valid(s)) walk = s;
      q.push_back(mk(s, v, $urandom_range(0, 19) == 0));
    end
    foreach (q[i]) begin
      run_step(q[i]);
      for (int k = 0; k < 3; k++) begin
        n_run++;
        if ({a_vld_w[k], a_out_w[k], err_w[k], locked_w[k]} !==
            {m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2} || obs_cnt[k] !== 8'(m_ecnt[k])) begin
          n_fail++;
          $display("FAIL random u%0d step %0d: vld/out/err/lock %b%b%b%b cnt %0d, expected %b%b%b%b cnt %0d",
                   k, i, a_vld_w[k], a_out_w[k], err_w[k], locked_w[k], obs_cnt[k],
                   m_avld[k], m_aout[k], m_err[k], m_mode[k] == 2, m_ecnt[k]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_invalid();
    test_saturate();
    test_svld();
    test_lock1();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
